crc32_frame_ctrl: RTL
=====================

# crc32_frame_ctrl

- Frame-level sequencer for the byte-wide `crc32` engine on the S1 data path.
- Takes a byte stream with valid/ready/last framing and forwards every payload byte downstream through one output register.
- Feeds each accepted byte to the engine, then appends the 4-byte FCS (CRC-32, reflected, init FFFFFFFF, final complement) with `m_last` on the final FCS byte.
- Clears the engine between frames and counts completed frames.

## Interface
- CNT_W, 16, width of the completed-frame counter
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- s_data  input  8  payload byte
- s_valid  input  1  s_data valid
- s_last  input  1  s_data is the last payload byte of the frame
- s_ready  output  1  block accepts s_data this cycle
- m_data  output  8  output byte (payload or FCS)
- m_valid  output  1  m_data valid
- m_last  output  1  m_data is the final FCS byte
- m_ready  input  1  downstream accepts m_data
- busy  output  1  state != IDLE
- frame_cnt  output  CNT_W  completed frames, wraps at 2^CNT_W

## Operation
- Input accept: acc = s_valid && s_ready.
- Output register "free": free = !m_valid || m_ready.
- States and transitions:
  - IDLE: s_ready = free. On acc, load the byte into the output register (m_last=0). Go to FCS if s_last, else DATA.
  - DATA: s_ready = free. On acc, load the byte. Go to FCS if s_last.
  - FCS: s_ready = 0. 2-bit idx from 0. On each free cycle, load crc32_out byte idx (idx0 = bits[7:0] … idx3 = bits[31:24]); m_last = (idx==3). After loading idx3, go to CLR and increment frame_cnt.
  - CLR: s_ready = 0; one cycle only; engine reinitialises; go to IDLE. The output register may still hold the idx3 byte and drains normally.
- Engine drive:
  - crc32_in = s_data.
  - valid = acc.
  - is_S1DATA = (state==DATA) || (state==FCS) || (state==IDLE && acc).
  - is_S1DATA low in IDLE and CLR keeps the engine state at FFFFFFFF.
- crc32_out is stable throughout FCS: is_S1DATA is high and valid is low there.
- m_data/m_valid/m_last hold while m_valid && !m_ready.
- Frames are at least 1 byte; zero-length frames cannot be expressed.
- No abort. `rst` is the only way to drop a frame in progress.

## Timing
- Reset values:
  - state = IDLE, idx = 0, frame_cnt = 0.
  - m_valid = 0, m_data = 0, m_last = 0.
  - s_ready = 1, busy = 0.
  - Engine register = FFFFFFFF.
- Latency: a byte accepted at edge N appears on m_data after edge N (1 cycle).
- Throughput: with m_ready held high, a frame of L bytes occupies L input cycles + 4 FCS cycles + 1 CLR cycle. The next frame's first byte can be accepted in the cycle after CLR.
- The first FCS byte is loaded at the first free edge after the last payload byte is accepted. It is back-to-back with the payload when m_ready=1.
- Backpressure: m_ready low stalls both payload and FCS emission; no byte is lost or duplicated.
- Simultaneous consume and load (m_valid && m_ready && new load) is a plain replace, with m_valid staying 1.
- Reset mid-frame: all outputs return to reset values asynchronously; the partial frame is discarded with no FCS and no frame_cnt increment.
- frame_cnt wraps from all-ones to 0.

## Structure
- Shared package `crc_pkg`:
  - state enum (IDLE, DATA, FCS, CLR);
  - CRC32_INIT = 32'hFFFFFFFF;
  - CRC32_RESIDUE = 32'hDEBB20E3 (for checker benches).
- One sub-module: instance of the existing `crc32` engine, with clk/rst shared.
- Everything else is the FSM plus the output register in this module.

## Test plan
- Frame ASCII "123456789" (31 32 … 39) with m_ready=1: output is the 9 bytes then 26 39 F4 CB. m_last only on CB. frame_cnt=1. Total frame time 14 cycles.
- Single-byte frame 00 (s_last on the first byte): output 00, 8D EF 02 D2. Then a single-byte frame 61 immediately after CLR: output 61, 43 BE B7 E8. This proves the engine re-initialises.
- Random m_ready toggling (50%) over 100 random frames of 1–64 bytes: output matches a model byte-for-byte. CRC-32 over payload+FCS always equals the residue DEBB20E3.
- s_valid presented during FCS/CLR: s_ready=0, no acceptance. After CLR, the byte is accepted as the start of the next frame.
- Assert rst at byte 5 of a 20-byte frame: m_valid=0 and busy=0 immediately, with no FCS emitted. Next frame "123456789" still yields CB F4 39 26 (sent as 26 39 F4 CB).
- With CNT_W=2, send 5 frames: frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions for the S1 data path: FSM states, constants, byte update.
package crc_pkg;

  typedef enum logic [1:0] {IDLE, DATA, FCS, CLR} state_t;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;

  // Reflected CRC-32 update of the raw register by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] r;
    r = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32.sv
// Byte-wide CRC-32 engine: updates on valid while is_S1DATA, reinitialises whenever is_S1DATA is low.
// crc32_out is the complemented register, i.e. the FCS of the bytes absorbed so far.
module crc32
  import crc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  crc32_in,
  input  logic        valid,
  input  logic        is_S1DATA,
  output logic [31:0] crc32_out
);

  logic [31:0] r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= CRC32_INIT;
    end else if (!is_S1DATA) begin
      r_crc <= CRC32_INIT;
    end else if (valid) begin
      r_crc <= crc32_byte(r_crc, crc32_in);
    end
  end

  assign crc32_out = ~r_crc;

endmodule

// File: rtl/crc32_frame_ctrl.sv
// Frame sequencer: forwards payload through one output register, appends the 4-byte FCS,
// clears the CRC engine between frames and counts completed frames.
module crc32_frame_ctrl
  import crc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [7:0]       r_m_data;
  logic             r_m_valid;
  logic             r_m_last;
  logic             w_free;
  logic             w_s_ready;
  logic             w_acc;
  logic             w_load;
  logic [7:0]       w_load_dat;
  logic             w_load_last;
  logic             w_cnt_inc;
  logic             w_is_s1data;
  logic [31:0]      w_crc;

  assign w_free      = !r_m_valid || m_ready;
  assign w_s_ready   = ((r_state == IDLE) || (r_state == DATA)) && w_free;
  assign w_acc       = s_valid && w_s_ready;
  // Open the engine on the accepting IDLE cycle so the first byte is absorbed from init.
  assign w_is_s1data = (r_state == DATA) || (r_state == FCS) || ((r_state == IDLE) && w_acc);

  crc32 u_crc32 (
    .clk       (clk),
    .rst       (rst),
    .crc32_in  (s_data),
    .valid     (w_acc),
    .is_S1DATA (w_is_s1data),
    .crc32_out (w_crc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_load_dat  = s_data;
    w_load_last = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      IDLE, DATA: begin
        if (w_acc) begin
          w_load      = 1'b1;
          w_state_nxt = s_last ? FCS : DATA;
        end
      end
      FCS: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_dat  = w_crc[{r_idx, 3'b000} +: 8];
          w_load_last = (r_idx == 2'd3);
          w_idx_nxt   = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_state_nxt = CLR;
            w_cnt_inc   = 1'b1;
          end
        end
      end
      CLR: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_cnt_inc) begin
        r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_data  <= 8'h00;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_load) begin
      r_m_data  <= w_load_dat;
      r_m_valid <= 1'b1;
      r_m_last  <= w_load_last;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_ready   = w_s_ready;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign busy      = (r_state != IDLE);
  assign frame_cnt = r_frame_cnt;

endmodule
